// File: rtl/busdebugger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : busdebugger_pkg
// Description : Shared encodings for the bus debugger capture path: FSM
//               states, trace-record flag bit positions and record widths.
// Revision    : 1.0 - initial release
// ============================================================================
package busdebugger_pkg;

    localparam int c_addr_w   = 32;
    localparam int c_data_w   = 32;
    localparam int c_flags_w  = 4;
    localparam int c_tmo_w    = 10;
    localparam int c_settle_w = 4;

    // rec_flags = {timeout, berr, dsack1, rw}
    localparam int c_flag_rw      = 0;
    localparam int c_flag_dsack1  = 1;
    localparam int c_flag_berr    = 2;
    localparam int c_flag_timeout = 3;

    localparam int c_state_w = 4;
    localparam logic [c_state_w-1:0] c_st_idle        = 4'd0;
    localparam logic [c_state_w-1:0] c_st_addr_settle = 4'd1;
    localparam logic [c_state_w-1:0] c_st_addr_latch  = 4'd2;
    localparam logic [c_state_w-1:0] c_st_wait_ds     = 4'd3;
    localparam logic [c_state_w-1:0] c_st_data_settle = 4'd4;
    localparam logic [c_state_w-1:0] c_st_wait_ack    = 4'd5;
    localparam logic [c_state_w-1:0] c_st_data_sample = 4'd6;
    localparam logic [c_state_w-1:0] c_st_emit        = 4'd7;
    localparam logic [c_state_w-1:0] c_st_wait_end    = 4'd8;
    localparam logic [c_state_w-1:0] c_st_dump        = 4'd9;

endpackage
`default_nettype wire

// File: rtl/strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : strobe_sync
// Description : Two-flop synchroniser for one asynchronous target strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/bus_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bus_capture_sequencer
// Description : Sequences AD-bus buffers/latch to capture each target bus
//               cycle as one trace record; yields buffers to the dump engine.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_capture_sequencer
    import busdebugger_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 comm_clock,
    input  logic                 reset,
    input  logic                 as_n,
    input  logic                 ds_n,
    input  logic                 rw,
    input  logic                 dsack0_n,
    input  logic                 dsack1_n,
    input  logic                 berr_n,
    input  logic [c_data_w-1:0]  ad_in,
    input  logic                 dump_req,
    output logic                 dump_grant,
    output logic                 addr_oe,
    output logic                 data_oe,
    output logic                 data_dir,
    output logic                 al_le,
    output logic                 rec_valid,
    output logic [c_addr_w-1:0]  rec_addr,
    output logic [c_data_w-1:0]  rec_data,
    output logic [c_flags_w-1:0] rec_flags,
    input  logic                 rec_ready,
    output logic                 overflow
);

    localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_CYCLES - 1);
    localparam logic [c_tmo_w-1:0]    c_tmo_load    = c_tmo_w'(TIMEOUT_CYCLES);

    logic w_as_n_s, w_ds_n_s, w_rw_s, w_dsack0_n_s, w_dsack1_n_s, w_berr_n_s;
    logic w_as, w_ds, w_dsack1, w_ack, w_berr, w_as_rise;

    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_next;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic [c_tmo_w-1:0]    r_tmo_cnt;
    logic                  r_as_d;

    strobe_sync #(.RESET_VAL(1'b1)) u_sync_as     (.clk(comm_clock), .rst(reset), .async_in(as_n),     .sync_out(w_as_n_s));
    strobe_sync #(.RESET_VAL(1'b1)) u_sync_ds     (.clk(comm_clock), .rst(reset), .async_in(ds_n),     .sync_out(w_ds_n_s));
    strobe_sync #(.RESET_VAL(1'b0)) u_sync_rw     (.clk(comm_clock), .rst(reset), .async_in(rw),       .sync_out(w_rw_s));
    strobe_sync #(.RESET_VAL(1'b1)) u_sync_dsack0 (.clk(comm_clock), .rst(reset), .async_in(dsack0_n), .sync_out(w_dsack0_n_s));
    strobe_sync #(.RESET_VAL(1'b1)) u_sync_dsack1 (.clk(comm_clock), .rst(reset), .async_in(dsack1_n), .sync_out(w_dsack1_n_s));
    strobe_sync #(.RESET_VAL(1'b1)) u_sync_berr   (.clk(comm_clock), .rst(reset), .async_in(berr_n),   .sync_out(w_berr_n_s));

    assign w_as     = ~w_as_n_s;
    assign w_ds     = ~w_ds_n_s;
    assign w_dsack1 = ~w_dsack1_n_s;
    assign w_ack    = ~w_dsack0_n_s | w_dsack1;
    assign w_berr   = ~w_berr_n_s;
    // Start only on a fresh AS assertion so a cycle already under way when
    // leaving DUMP or a WAIT_END timeout is never captured mid-flight.
    assign w_as_rise = w_as & ~r_as_d;

    always_ff @(posedge comm_clock) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (dump_req)       w_next = c_st_dump;
                else if (w_as_rise) w_next = c_st_addr_settle;
            end
            c_st_addr_settle: if (r_settle_cnt == '0) w_next = c_st_addr_latch;
            c_st_addr_latch:  w_next = c_st_wait_ds;
            c_st_wait_ds: begin
                if (!w_as)     w_next = c_st_idle;
                else if (w_ds) w_next = c_st_data_settle;
            end
            c_st_data_settle: if (r_settle_cnt == '0) w_next = c_st_wait_ack;
            c_st_wait_ack:    if (w_ack || w_berr || r_tmo_cnt == '0) w_next = c_st_data_sample;
            c_st_data_sample: w_next = c_st_emit;
            c_st_emit:        w_next = c_st_wait_end;
            c_st_wait_end:    if (!w_as || r_tmo_cnt == '0) w_next = c_st_idle;
            c_st_dump:        if (!dump_req) w_next = c_st_idle;
            default:          w_next = c_st_idle;
        endcase
    end

    always_comb begin
        addr_oe    = (r_state == c_st_addr_settle) || (r_state == c_st_addr_latch);
        data_oe    = (r_state == c_st_data_settle) || (r_state == c_st_wait_ack) ||
                     (r_state == c_st_data_sample);
        al_le      = (r_state == c_st_addr_latch);
        rec_valid  = (r_state == c_st_emit) && rec_ready;
        dump_grant = (r_state == c_st_dump);
        data_dir   = 1'b0;
    end

    // Datapath: counters, record fields and the sticky overflow flag.
    always_ff @(posedge comm_clock) begin
        if (reset) begin
            r_as_d       <= 1'b0;
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
            rec_addr     <= '0;
            rec_data     <= '0;
            rec_flags    <= '0;
            overflow     <= 1'b0;
        end else begin
            r_as_d <= w_as;
            case (r_state)
                c_st_idle: begin
                    if (w_next == c_st_addr_settle) r_settle_cnt <= c_settle_load;
                end
                c_st_addr_settle: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
                end
                c_st_addr_latch: begin
                    rec_addr  <= ad_in;
                    rec_flags <= '0;
                    rec_flags[c_flag_rw] <= w_rw_s;
                    r_tmo_cnt <= c_tmo_load;
                end
                c_st_wait_ds: begin
                    if (w_next == c_st_data_settle) r_settle_cnt <= c_settle_load;
                end
                c_st_data_settle: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
                    else                    r_tmo_cnt    <= c_tmo_load;
                end
                c_st_wait_ack: begin
                    if (w_ack || w_berr) begin
                        rec_flags[c_flag_dsack1] <= w_dsack1;
                        rec_flags[c_flag_berr]   <= w_berr;
                    end else if (r_tmo_cnt == '0) begin
                        rec_flags[c_flag_timeout] <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
                    end
                end
                c_st_data_sample: rec_data <= ad_in;
                c_st_emit: begin
                    r_tmo_cnt <= c_tmo_load;
                    if (!rec_ready) overflow <= 1'b1;
                end
                c_st_wait_end: begin
                    if (r_tmo_cnt != '0) r_tmo_cnt <= r_tmo_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assert property (@(posedge comm_clock) disable iff (reset) !(addr_oe && data_oe));

endmodule
`default_nettype wire

// File: tb/tb_bus_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_capture_sequencer
// Description : Self-checking bench for bus_capture_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_capture_sequencer;

    logic        clk;
    logic        rst;
    logic        as_n, ds_n, rw, dsack0_n, dsack1_n, berr_n;
    logic [31:0] ad_in;
    logic        dump_req, dump_grant;
    logic        addr_oe, data_oe, data_dir, al_le;
    logic        rec_valid, rec_ready, overflow;
    logic [31:0] rec_addr, rec_data;
    logic [3:0]  rec_flags;

    logic [31:0] cur_addr, cur_data;
    int          checks, failures;
    int          rec_cnt, en_cnt;
    logic [31:0] last_addr, last_data;
    logic [3:0]  last_flags;

    bus_capture_sequencer #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(1023)) dut (
        .comm_clock(clk), .reset(rst),
        .as_n(as_n), .ds_n(ds_n), .rw(rw),
        .dsack0_n(dsack0_n), .dsack1_n(dsack1_n), .berr_n(berr_n),
        .ad_in(ad_in), .dump_req(dump_req), .dump_grant(dump_grant),
        .addr_oe(addr_oe), .data_oe(data_oe), .data_dir(data_dir), .al_le(al_le),
        .rec_valid(rec_valid), .rec_addr(rec_addr), .rec_data(rec_data),
        .rec_flags(rec_flags), .rec_ready(rec_ready), .overflow(overflow)
    );

    // Target-side buffer model: AD carries whichever phase is enabled.
    assign ad_in = addr_oe ? cur_addr : (data_oe ? cur_data : 32'h0BAD_F00D);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (addr_oe || data_oe || al_le) en_cnt++;
        if (addr_oe && data_oe) begin
            failures++;
            $display("FAIL enable_overlap actual=11 required=not both");
        end
        if (rec_valid) begin
            rec_cnt++;
            last_addr  = rec_addr;
            last_data  = rec_data;
            last_flags = rec_flags;
            checks++;
            if (data_oe !== 1'b0) begin
                failures++;
                $display("FAIL data_oe_at_emit actual=%b required=0", data_oe);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic release_strobes();
        as_n = 1'b1; ds_n = 1'b1; dsack0_n = 1'b1; dsack1_n = 1'b1; berr_n = 1'b1;
    endtask

    // kind: 0=dsack1, 1=dsack0, 2=berr, 3=both dsacks
    task automatic run_cycle(input logic rw_i, input logic [31:0] a, input logic [31:0] d,
                             input int kind, input logic ready);
        cur_addr = a; cur_data = d; rec_ready = ready;
        rw = rw_i; as_n = 1'b0;
        tick(2);
        ds_n = 1'b0;
        tick(5);
        case (kind)
            0: dsack1_n = 1'b0;
            1: dsack0_n = 1'b0;
            2: berr_n = 1'b0;
            default: begin dsack0_n = 1'b0; dsack1_n = 1'b0; end
        endcase
        tick(20);
        release_strobes();
        tick(6);
        rec_ready = 1'b1;
    endtask

    task automatic probe_idle(input string name);
        dump_req = 1'b1;
        tick(1);
        check({name, "_grant"}, {31'b0, dump_grant}, 32'd1);
        dump_req = 1'b0;
        tick(1);
        check({name, "_release"}, {31'b0, dump_grant}, 32'd0);
    endtask

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        int          kind;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int c0, e0, n;
        vecs[0] = '{1'b1, 32'h00FF_1234, 32'hDEAD_BEEF, 0, 4'b0011};
        vecs[1] = '{1'b0, 32'h1234_5678, 32'hCAFE_F00D, 2, 4'b0100};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1, 4'b0001};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 4'b0010};
        vecs[4] = '{1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3, 4'b0011};

        checks = 0; failures = 0; rec_cnt = 0; en_cnt = 0;
        last_addr = '0; last_data = '0; last_flags = '0;
        cur_addr = '0; cur_data = '0;
        rw = 1'b0; dump_req = 1'b0; rec_ready = 1'b1;
        release_strobes();
        rst = 1'b1;
        tick(3);

        check("rst_addr_oe", {31'b0, addr_oe}, 32'd0);
        check("rst_data_oe", {31'b0, data_oe}, 32'd0);
        check("rst_al_le", {31'b0, al_le}, 32'd0);
        check("rst_dump_grant", {31'b0, dump_grant}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_rec_addr", rec_addr, 32'd0);
        check("rst_rec_data", rec_data, 32'd0);
        check("rst_rec_flags", {28'b0, rec_flags}, 32'd0);
        check("data_dir", {31'b0, data_dir}, 32'd0);
        rst = 1'b0;
        tick(3);
        check("idle_rec_valid", {31'b0, rec_valid}, 32'd0);

        // Latency: AS edge -> addr_oe (3), -> al_le (5), sync ack -> rec_valid (2)
        cur_addr = 32'h0101_0202; cur_data = 32'h0303_0404;
        rw = 1'b1; as_n = 1'b0; ds_n = 1'b0;
        tick(2);
        check("lat_addr_oe_e2", {31'b0, addr_oe}, 32'd0);
        tick(1);
        check("lat_addr_oe_e3", {31'b0, addr_oe}, 32'd1);
        tick(1);
        check("lat_al_le_e4", {31'b0, al_le}, 32'd0);
        tick(1);
        check("lat_al_le_e5", {31'b0, al_le}, 32'd1);
        tick(1);
        check("lat_al_le_e6", {31'b0, al_le}, 32'd0);
        check("lat_addr_oe_e6", {31'b0, addr_oe}, 32'd0);
        tick(3);
        check("lat_data_oe_e9", {31'b0, data_oe}, 32'd1);
        tick(1);
        dsack1_n = 1'b0;
        tick(3);
        check("lat_rec_valid_e13", {31'b0, rec_valid}, 32'd0);
        check("lat_data_oe_sample", {31'b0, data_oe}, 32'd1);
        tick(1);
        check("lat_rec_valid_e14", {31'b0, rec_valid}, 32'd1);
        check("lat_rec_addr", rec_addr, 32'h0101_0202);
        check("lat_rec_data", rec_data, 32'h0303_0404);
        tick(1);
        check("lat_rec_valid_e15", {31'b0, rec_valid}, 32'd0);
        release_strobes();
        tick(6);

        for (int i = 0; i < 5; i++) begin
            c0 = rec_cnt;
            run_cycle(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].kind, 1'b1);
            check($sformatf("vec%0d_count", i), rec_cnt - c0, 32'd1);
            check($sformatf("vec%0d_addr", i), last_addr, vecs[i].addr);
            check($sformatf("vec%0d_data", i), last_data, vecs[i].data);
            check($sformatf("vec%0d_flags", i), {28'b0, last_flags}, {28'b0, vecs[i].exp_flags});
            check($sformatf("vec%0d_overflow", i), {31'b0, overflow}, 32'd0);
        end

        // Timeout: DS asserted, no ack ever
        cur_addr = 32'h1357_2468; cur_data = 32'h2468_ACE0;
        c0 = rec_cnt;
        rw = 1'b1; as_n = 1'b0; ds_n = 1'b0;
        n = 0;
        while (n < 1300 && rec_cnt == c0) begin
            tick(1);
            n++;
        end
        check("tmo_count", rec_cnt - c0, 32'd1);
        check("tmo_latency_window", {31'b0, (n >= 1030 && n <= 1040)}, 32'd1);
        check("tmo_flags", {28'b0, last_flags}, 32'h9);
        check("tmo_addr", last_addr, 32'h1357_2468);
        check("tmo_data", last_data, 32'h2468_ACE0);
        release_strobes();
        tick(4);
        probe_idle("tmo_idle");
        tick(4);

        // Dump request wins over AS arriving on the same cycle
        cur_addr = 32'h7777_0000; cur_data = 32'h0000_7777;
        rw = 1'b1; as_n = 1'b0; ds_n = 1'b0;
        tick(2);
        dump_req = 1'b1;
        e0 = en_cnt; c0 = rec_cnt;
        tick(1);
        check("dump_grant_rise", {31'b0, dump_grant}, 32'd1);
        check("dump_addr_oe", {31'b0, addr_oe}, 32'd0);
        tick(10);
        check("dump_no_enables", en_cnt - e0, 32'd0);
        dump_req = 1'b0;
        tick(1);
        check("dump_grant_fall", {31'b0, dump_grant}, 32'd0);
        tick(10);
        check("dump_inflight_skipped", en_cnt - e0, 32'd0);
        check("dump_no_record", rec_cnt - c0, 32'd0);
        release_strobes();
        tick(6);
        run_cycle(1'b0, 32'h00C0_FFEE, 32'h1122_3344, 0, 1'b1);
        check("post_dump_count", rec_cnt - c0, 32'd1);
        check("post_dump_addr", last_addr, 32'h00C0_FFEE);
        check("post_dump_flags", {28'b0, last_flags}, 32'h2);

        // Trace buffer full during EMIT
        c0 = rec_cnt;
        run_cycle(1'b1, 32'h4444_5555, 32'h6666_7777, 0, 1'b0);
        check("ovf_no_record", rec_cnt - c0, 32'd0);
        check("ovf_set", {31'b0, overflow}, 32'd1);
        tick(20);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);
        run_cycle(1'b1, 32'h8888_9999, 32'hAAAA_BBBB, 1, 1'b1);
        check("ovf_next_record", rec_cnt - c0, 32'd1);
        check("ovf_still_set", {31'b0, overflow}, 32'd1);

        // Reset while waiting for ack
        cur_addr = 32'hFACE_0001; cur_data = 32'hFACE_0002;
        c0 = rec_cnt;
        rw = 1'b1; as_n = 1'b0; ds_n = 1'b0;
        tick(20);
        check("rst_mid_data_oe_before", {31'b0, data_oe}, 32'd1);
        rst = 1'b1;
        release_strobes();
        tick(1);
        check("rst_mid_data_oe", {31'b0, data_oe}, 32'd0);
        check("rst_mid_overflow", {31'b0, overflow}, 32'd0);
        check("rst_mid_rec_addr", rec_addr, 32'd0);
        check("rst_mid_rec_flags", {28'b0, rec_flags}, 32'd0);
        rst = 1'b0;
        e0 = en_cnt;
        tick(30);
        check("rst_mid_no_record", rec_cnt - c0, 32'd0);
        check("rst_mid_no_enables", en_cnt - e0, 32'd0);
        probe_idle("rst_mid_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
